ucc_issue_ctrl: RTL and testbench

- Sequential stage directly upstream of the 8-bit universal cell (UCC8Bit).
- Buffers operation commands (cin, fin, pin, m) in a small FIFO and drives them onto the cell's inputs, holding them stable.
- Waits a programmable settle time, then captures the cell's outputs (cout, fout, mo) into a result register.
- Presents that result with a valid/ready handshake to the next stage.

---
 rtl/ucc_issue_ctrl_if.sv | 50 +++++
 rtl/ucc_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ucc_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ucc_issue_ctrl_if.sv
// Interface bundling the command, cell and result signals of ucc_issue_ctrl.
// slave  : the issue controller's view.
// master : the surrounding environment (command source, cell, result sink).
interface ucc_issue_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_cin;
  logic [WIDTH-1:0] cmd_fin;
  logic [WIDTH-1:0] cmd_pin;
  logic [1:0]       cmd_m;

  logic             ucc_cin;
  logic [WIDTH-1:0] ucc_fin;
  logic [WIDTH-1:0] ucc_pin;
  logic [1:0]       ucc_m;
  logic             ucc_cout;
  logic [WIDTH-1:0] ucc_fout;
  logic [1:0]       ucc_mo;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_fout;
  logic             res_cout;
  logic [1:0]       res_mo;
  logic             res_err;

  logic             busy;

  modport slave (
    input  cmd_valid, cmd_cin, cmd_fin, cmd_pin, cmd_m,
    output cmd_ready,
    output ucc_cin, ucc_fin, ucc_pin, ucc_m,
    input  ucc_cout, ucc_fout, ucc_mo,
    output res_valid, res_fout, res_cout, res_mo, res_err,
    input  res_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_cin, cmd_fin, cmd_pin, cmd_m,
    input  cmd_ready,
    input  ucc_cin, ucc_fin, ucc_pin, ucc_m,
    output ucc_cout, ucc_fout, ucc_mo,
    input  res_valid, res_fout, res_cout, res_mo, res_err,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/ucc_issue_ctrl.sv
// Issue controller for the 8-bit universal cell: queues commands, holds them
// on the cell inputs for SETTLE_CYCLES, captures the cell outputs and offers
// the result through a valid/ready handshake.
// Optional: define UCC_MODE_CHECK_EN to flag (sticky) a cell mode echo that
// differs from the driven mode.
module ucc_issue_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  ucc_issue_ctrl_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned EW = 2 * WIDTH + 3;
  localparam logic [AW:0]   FullCnt   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] SettleCnt = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, push, pop, capture;
  logic [EW-1:0]    head;

  logic             ucc_cin_q;
  logic [WIDTH-1:0] ucc_fin_q, ucc_pin_q;
  logic [1:0]       ucc_m_q;

  logic             res_valid_q, res_cout_q;
  logic [WIDTH-1:0] res_fout_q;
  logic [1:0]       res_mo_q;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
  assign push  = bus.cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Sequencing: pop/drive, settle countdown, capture, handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = SettleCnt;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.res_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            cnt_d   = SettleCnt;
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO occupancy update.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM, settle counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_cin, bus.cmd_fin, bus.cmd_pin, bus.cmd_m};
    end
  end

  // Cell operand registers: load on pop, otherwise hold the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucc_cin_q <= 1'b0;
      ucc_fin_q <= '0;
      ucc_pin_q <= '0;
      ucc_m_q   <= '0;
    end else if (pop) begin
      ucc_cin_q <= head[EW-1];
      ucc_fin_q <= head[EW-2 -: WIDTH];
      ucc_pin_q <= head[WIDTH+1 -: WIDTH];
      ucc_m_q   <= head[1:0];
    end
  end

  // Result register and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_fout_q  <= '0;
      res_cout_q  <= 1'b0;
      res_mo_q    <= '0;
    end else begin
      if (capture) begin
        res_valid_q <= 1'b1;
        res_fout_q  <= bus.ucc_fout;
        res_cout_q  <= bus.ucc_cout;
        res_mo_q    <= bus.ucc_mo;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef UCC_MODE_CHECK_EN
  logic res_err_q;

  // Sticky mode-echo error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else if (capture && (bus.ucc_mo != ucc_m_q)) begin
      res_err_q <= 1'b1;
    end
  end

  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.cmd_ready = !full;
  assign bus.ucc_cin   = ucc_cin_q;
  assign bus.ucc_fin   = ucc_fin_q;
  assign bus.ucc_pin   = ucc_pin_q;
  assign bus.ucc_m     = ucc_m_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_fout  = res_fout_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_mo    = res_mo_q;
  assign bus.busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_ucc_issue_ctrl.sv
// Self-checking bench for ucc_issue_ctrl with an adder stub standing in for
// the universal cell (fout = fin + pin + cin, cout = carry, mo = m).
module tb_ucc_issue_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 4;
`ifdef UCC_MODE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic bad_mo;
  logic [WIDTH:0] sum;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ucc_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

  ucc_issue_ctrl #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Cell stub; bad_mo corrupts the mode echo for m == 1.
  assign sum          = {1'b0, bus.ucc_fin} + {1'b0, bus.ucc_pin} + {8'd0, bus.ucc_cin};
  assign bus.ucc_fout = sum[WIDTH-1:0];
  assign bus.ucc_cout = sum[WIDTH];
  assign bus.ucc_mo   = (bad_mo && bus.ucc_m == 2'd1) ? 2'd2 : bus.ucc_m;

  typedef struct {
    logic       cin;
    logic [7:0] fin;
    logic [7:0] pin;
    logic [1:0] m;
    logic [7:0] fout;
    logic       cout;
    logic [1:0] mo;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic cin, input logic [7:0] fin, input logic [7:0] pin,
                      input logic [1:0] m);
    bus.cmd_cin   = cin;
    bus.cmd_fin   = fin;
    bus.cmd_pin   = pin;
    bus.cmd_m     = m;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;

    vecs[0] = '{cin: 1'b1, fin: 8'd200, pin: 8'd100, m: 2'd3, fout: 8'd45,  cout: 1'b1, mo: 2'd3};
    vecs[1] = '{cin: 1'b0, fin: 8'd255, pin: 8'd1,   m: 2'd2, fout: 8'd0,   cout: 1'b1, mo: 2'd2};
    vecs[2] = '{cin: 1'b0, fin: 8'd0,   pin: 8'd0,   m: 2'd1, fout: 8'd0,   cout: 1'b0, mo: 2'd1};
    vecs[3] = '{cin: 1'b1, fin: 8'd127, pin: 8'd127, m: 2'd2, fout: 8'd255, cout: 1'b0, mo: 2'd2};
    vecs[4] = '{cin: 1'b0, fin: 8'd128, pin: 8'd128, m: 2'd0, fout: 8'd0,   cout: 1'b1, mo: 2'd0};
    vecs[5] = '{cin: 1'b1, fin: 8'd255, pin: 8'd255, m: 2'd3, fout: 8'd255, cout: 1'b1, mo: 2'd3};

    rst           = 1'b1;
    bad_mo        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_cin   = 1'b0;
    bus.cmd_fin   = '0;
    bus.cmd_pin   = '0;
    bus.cmd_m     = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_ucc_fin",   32'(bus.ucc_fin),   32'd0);
    chk("rst_res_fout",  32'(bus.res_fout),  32'd0);
    chk("rst_res_err",   32'(bus.res_err),   32'd0);

    // Single op: accept at E0, pop at E1, result after E5
    bus.res_ready = 1'b1;
    push(1'b1, 8'd7, 8'd10, 2'd0);
    chk("single_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("single_ucc_fin_e1", 32'(bus.ucc_fin), 32'd7);
    for (int i = 0; i < 3; i++) tick();
    chk("single_not_valid_e4", 32'(bus.res_valid), 32'd0);
    chk("single_ucc_fin_e4", 32'(bus.ucc_fin), 32'd7);
    tick();
    chk("single_valid_e5", 32'(bus.res_valid), 32'd1);
    chk("single_fout", 32'(bus.res_fout), 32'd18);
    chk("single_cout", 32'(bus.res_cout), 32'd0);
    chk("single_mo",   32'(bus.res_mo),   32'd0);
    tick();
    chk("single_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("single_busy_drop",  32'(bus.busy),      32'd0);
    chk("single_ucc_hold",   32'(bus.ucc_fin),   32'd7);
    chk("single_res_hold",   32'(bus.res_fout),  32'd18);

    // Table-driven vectors, one command at a time
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].cin, vecs[v].fin, vecs[v].pin, vecs[v].m);
      wait_valid("vec_valid", n);
      chk("vec_latency", 32'(n), 32'(SETTLE + 1));
      chk("vec_fout", 32'(bus.res_fout), 32'(vecs[v].fout));
      chk("vec_cout", 32'(bus.res_cout), 32'(vecs[v].cout));
      chk("vec_mo",   32'(bus.res_mo),   32'(vecs[v].mo));
      tick();
    end

    // Fill and back-pressure
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(1'b0, 8'(10 + k), 8'(k), 2'(k));
    chk("fill_cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_cin   = 1'b0;
    bus.cmd_fin   = 8'd99;
    bus.cmd_pin   = 8'd99;
    bus.cmd_m     = 2'd0;
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    chk("fill_cmd_ready_still", 32'(bus.cmd_ready), 32'd0);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid("fill_valid", n);
      if (k > 0) chk("fill_gap", 32'(n), 32'(SETTLE));
      chk("fill_fout", 32'(bus.res_fout), 32'(10 + 2 * k));
      chk("fill_mo",   32'(bus.res_mo),   32'(k % 4));
      tick();
    end
    chk("fill_busy_end", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.res_valid) seen = 1'b1;
    end
    chk("fill_no_sixth", 32'(seen), 32'd0);

    // Simultaneous push/pop at the HOLD handshake with 3 queued
    bus.res_ready = 1'b0;
    for (int j = 0; j < 4; j++) push(1'b0, 8'(50 + j), 8'd1, 2'd0);
    wait_valid("pp_first_valid", n);
    chk("pp_first_fout", 32'(bus.res_fout), 32'd51);
    bus.cmd_cin   = 1'b0;
    bus.cmd_fin   = 8'd54;
    bus.cmd_pin   = 8'd1;
    bus.cmd_m     = 2'd0;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("pp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("pp_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("pp_ucc_fin", 32'(bus.ucc_fin), 32'd51);
    for (int j = 1; j < 5; j++) begin
      wait_valid("pp_valid", n);
      chk("pp_fout", 32'(bus.res_fout), 32'(51 + j));
      tick();
    end
    chk("pp_busy_end", 32'(bus.busy), 32'd0);

    // Reset during DRIVE with 2 queued
    bus.res_ready = 1'b0;
    for (int j = 0; j < 3; j++) push(1'b1, 8'(48 + j), 8'd1, 2'd3);
    chk("rmid_busy", 32'(bus.busy), 32'd1);
    do_reset();
    chk("rmid_res_valid",  32'(bus.res_valid), 32'd0);
    chk("rmid_ucc_fin",    32'(bus.ucc_fin),   32'd0);
    chk("rmid_ucc_cin",    32'(bus.ucc_cin),   32'd0);
    chk("rmid_ucc_m",      32'(bus.ucc_m),     32'd0);
    chk("rmid_cmd_ready",  32'(bus.cmd_ready), 32'd1);
    chk("rmid_busy_after", 32'(bus.busy),      32'd0);
    chk("rmid_res_fout",   32'(bus.res_fout),  32'd0);
    bus.res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.res_valid) seen = 1'b1;
    end
    chk("rmid_no_stale", 32'(seen), 32'd0);

    // Mode-check error: sticky until reset
    bad_mo = 1'b1;
    push(1'b0, 8'd3, 8'd4, 2'd1);
    wait_valid("err_valid", n);
    chk("err_mo",  32'(bus.res_mo),  32'd2);
    chk("err_set", 32'(bus.res_err), 32'(EXP_ERR));
    tick();
    push(1'b0, 8'd1, 8'd1, 2'd2);
    wait_valid("err_valid2", n);
    chk("err_fout2",  32'(bus.res_fout), 32'd2);
    chk("err_sticky", 32'(bus.res_err),  32'(EXP_ERR));
    tick();
    chk("err_sticky_idle", 32'(bus.res_err), 32'(EXP_ERR));
    bad_mo = 1'b0;
    do_reset();
    chk("err_cleared", 32'(bus.res_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
